// File: rtl/dyn_mem_bkgp_ctrl_if.sv
// TCDM bank-group request/response bus.
// master = crossbar side, slave = bank-group controller.
interface dyn_mem_bkgp_ctrl_if #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 10
);
  localparam int StrbWidth = DATA_WIDTH / 8;

  logic                  tcdm_req_i;
  logic [ADDR_WIDTH-1:0] tcdm_addr_i;
  logic                  tcdm_we_i;
  logic [DATA_WIDTH-1:0] tcdm_wdata_i;
  logic [StrbWidth-1:0]  tcdm_strb_i;
  logic                  tcdm_gnt_o;
  logic [DATA_WIDTH-1:0] tcdm_rdata_o;
  logic                  tcdm_rvalid_o;
  logic                  tcdm_ecc_err_o;

  modport master (
    output tcdm_req_i,
    output tcdm_addr_i,
    output tcdm_we_i,
    output tcdm_wdata_i,
    output tcdm_strb_i,
    input  tcdm_gnt_o,
    input  tcdm_rdata_o,
    input  tcdm_rvalid_o,
    input  tcdm_ecc_err_o
  );

  modport slave (
    input  tcdm_req_i,
    input  tcdm_addr_i,
    input  tcdm_we_i,
    input  tcdm_wdata_i,
    input  tcdm_strb_i,
    output tcdm_gnt_o,
    output tcdm_rdata_o,
    output tcdm_rvalid_o,
    output tcdm_ecc_err_o
  );
endinterface

// File: rtl/dyn_mem_bkgp_ctrl.sv
// Bank-group controller: TCDM requests -> single-port SRAM, 1-cycle reads.
// Ports: clk_i, rst_i (async, active-high), tcdm (slave bus), sram_* access
// port, err_cnt_o. Macro DYN_MEM_BKGP_PARITY_EN adds word parity + RMW.
module dyn_mem_bkgp_ctrl #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 10,
  parameter int CNT_WIDTH  = 16,
  localparam int StrbWidth = DATA_WIDTH / 8,
`ifdef DYN_MEM_BKGP_PARITY_EN
  localparam int SramWidth = DATA_WIDTH + 1
`else
  localparam int SramWidth = DATA_WIDTH
`endif
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  dyn_mem_bkgp_ctrl_if.slave    tcdm,
  output logic                  sram_req_o,
  output logic                  sram_we_o,
  output logic [ADDR_WIDTH-1:0] sram_addr_o,
  output logic [SramWidth-1:0]  sram_wdata_o,
  output logic [StrbWidth-1:0]  sram_be_o,
  input  logic [SramWidth-1:0]  sram_rdata_i,
  output logic [CNT_WIDTH-1:0]  err_cnt_o
);

  logic req;
  logic we;
  logic no_b;

  // nothing is granted or issued while reset is held
  assign req  = tcdm.tcdm_req_i & ~rst_i;
  assign we   = tcdm.tcdm_we_i;
  assign no_b = ~|tcdm.tcdm_strb_i;

  logic                  gnt;
  logic                  rvalid_q;
  logic                  a_req;
  logic                  a_we;
  logic [ADDR_WIDTH-1:0] a_addr;
  logic [SramWidth-1:0]  a_wdata;
  logic [StrbWidth-1:0]  a_be;

  assign tcdm.tcdm_gnt_o    = gnt;
  assign tcdm.tcdm_rvalid_o = rvalid_q;
  assign tcdm.tcdm_rdata_o  = sram_rdata_i[DATA_WIDTH-1:0];

  // idle SRAM bus is held at zero
  assign sram_req_o   = a_req;
  assign sram_we_o    = a_req & a_we;
  assign sram_addr_o  = a_req ? a_addr : '0;
  assign sram_wdata_o = a_req ? a_wdata : '0;
  assign sram_be_o    = a_req ? a_be : '0;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rvalid_q <= 1'b0;
    end else begin
      rvalid_q <= req & gnt;
    end
  end

`ifdef DYN_MEM_BKGP_PARITY_EN

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] MERGE = 1'b1;

  logic [0:0]            state_q;
  logic [0:0]            state_d;
  logic                  all_b;
  logic                  cap_en;
  logic                  rd_q;
  logic                  rd_par;
  logic                  ecc_err;
  logic                  merge_err;
  logic [ADDR_WIDTH-1:0] cap_addr_q;
  logic [DATA_WIDTH-1:0] cap_wdata_q;
  logic [StrbWidth-1:0]  cap_strb_q;
  logic [DATA_WIDTH-1:0] merged;
  logic [CNT_WIDTH-1:0]  cnt_q;

  assign all_b  = &tcdm.tcdm_strb_i;
  // stored words carry even parity, so any set xor is a fault
  assign rd_par = ^sram_rdata_i;

  always_comb begin
    merged = '0;
    for (int b = 0; b < StrbWidth; b++) begin
      merged[b*8 +: 8] = cap_strb_q[b] ?
        cap_wdata_q[b*8 +: 8] : sram_rdata_i[b*8 +: 8];
    end
  end

  always_comb begin
    state_d = state_q;
    gnt     = 1'b0;
    a_req   = 1'b0;
    a_we    = 1'b0;
    a_addr  = tcdm.tcdm_addr_i;
    a_wdata = {^tcdm.tcdm_wdata_i, tcdm.tcdm_wdata_i};
    a_be    = '1;
    cap_en  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          if (!we) begin
            gnt   = 1'b1;
            a_req = 1'b1;
          end else if (all_b) begin
            gnt   = 1'b1;
            a_req = 1'b1;
            a_we  = 1'b1;
          end else if (no_b) begin
            gnt = 1'b1;
          end else begin
            a_req   = 1'b1;
            cap_en  = 1'b1;
            state_d = MERGE;
          end
        end
      end
      MERGE: begin
        // write completes even if the master misbehaves
        gnt     = req;
        a_req   = 1'b1;
        a_we    = 1'b1;
        a_addr  = cap_addr_q;
        a_wdata = {^merged, merged};
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      rd_q        <= 1'b0;
      cap_addr_q  <= '0;
      cap_wdata_q <= '0;
      cap_strb_q  <= '0;
    end else begin
      state_q <= state_d;
      rd_q    <= req & gnt & ~we;
      if (cap_en) begin
        cap_addr_q  <= tcdm.tcdm_addr_i;
        cap_wdata_q <= tcdm.tcdm_wdata_i;
        cap_strb_q  <= tcdm.tcdm_strb_i;
      end
    end
  end

  assign ecc_err   = rvalid_q & rd_q & rd_par;
  // MERGE never follows a granted cycle, so the two never overlap
  assign merge_err = (state_q == MERGE) & rd_par;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if ((ecc_err | merge_err) && !(&cnt_q)) begin
      cnt_q <= cnt_q + CNT_WIDTH'(1);
    end
  end

  assign tcdm.tcdm_ecc_err_o = ecc_err;
  assign err_cnt_o           = cnt_q;

  a_merge_req_held: assert property (
    @(posedge clk_i) disable iff (rst_i)
    state_q == MERGE |-> tcdm.tcdm_req_i
  );

`else

  always_comb begin
    gnt     = req;
    a_req   = req & ~(we & no_b);
    a_we    = we;
    a_addr  = tcdm.tcdm_addr_i;
    a_wdata = tcdm.tcdm_wdata_i;
    a_be    = we ? tcdm.tcdm_strb_i : '1;
  end

  assign tcdm.tcdm_ecc_err_o = 1'b0;
  assign err_cnt_o           = '0;

`endif

endmodule

// File: tb/tb_dyn_mem_bkgp_ctrl.sv
// Directed bench for dyn_mem_bkgp_ctrl with a behavioural SRAM.
// Works with or without DYN_MEM_BKGP_PARITY_EN.
module tb_dyn_mem_bkgp_ctrl;
  localparam int DW = 64;
  localparam int AW = 10;
  localparam int CW = 2;
  localparam int BW = DW / 8;
`ifdef DYN_MEM_BKGP_PARITY_EN
  localparam int SW = DW + 1;
`else
  localparam int SW = DW;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dyn_mem_bkgp_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  logic          sram_req;
  logic          sram_we;
  logic [AW-1:0] sram_addr;
  logic [SW-1:0] sram_wdata;
  logic [BW-1:0] sram_be;
  logic [SW-1:0] sram_rdata;
  logic [CW-1:0] err_cnt;

  dyn_mem_bkgp_ctrl #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .CNT_WIDTH (CW)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .tcdm        (bus),
    .sram_req_o  (sram_req),
    .sram_we_o   (sram_we),
    .sram_addr_o (sram_addr),
    .sram_wdata_o(sram_wdata),
    .sram_be_o   (sram_be),
    .sram_rdata_i(sram_rdata),
    .err_cnt_o   (err_cnt)
  );

  logic [SW-1:0] mem [0:(1<<AW)-1];
  logic [SW-1:0] wr_word;
  logic          flip_req;
  logic [AW-1:0] flip_addr;

  always_comb begin
    wr_word = mem[sram_addr];
    for (int b = 0; b < BW; b++)
      if (sram_be[b]) wr_word[b*8 +: 8] = sram_wdata[b*8 +: 8];
`ifdef DYN_MEM_BKGP_PARITY_EN
    wr_word[DW] = sram_wdata[DW];
`endif
  end

  always @(posedge clk) begin
    if (flip_req) mem[flip_addr][3] <= ~mem[flip_addr][3];
    if (sram_req) begin
      if (sram_we) mem[sram_addr] <= wr_word;
      else sram_rdata <= mem[sram_addr];
    end
  end

  int checks = 0;
  int errors = 0;

  function automatic logic [SW-1:0] mk(input logic [DW-1:0] d);
`ifdef DYN_MEM_BKGP_PARITY_EN
    mk = {^d, d};
`else
    mk = d;
`endif
  endfunction

  function automatic logic [DW-1:0] sd(input int i);
    sd = {32'hC0DE0000 + 32'(i), 32'h5A5A0000 + 32'(i)};
  endfunction

  task automatic chk1(input string t, input logic o, input logic e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s got %h want %h", t, o, e);
    end
  endtask

  task automatic chkd(input string t, input logic [DW-1:0] o,
                      input logic [DW-1:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s got %h want %h", t, o, e);
    end
  endtask

  task automatic chks(input string t, input logic [SW-1:0] o,
                      input logic [SW-1:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s got %h want %h", t, o, e);
    end
  endtask

  task automatic chkb(input string t, input logic [BW-1:0] o,
                      input logic [BW-1:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s got %h want %h", t, o, e);
    end
  endtask

  task automatic chkc(input string t, input logic [CW-1:0] o,
                      input logic [CW-1:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s got %h want %h", t, o, e);
    end
  endtask

  task automatic chka(input string t, input logic [AW-1:0] o,
                      input logic [AW-1:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s got %h want %h", t, o, e);
    end
  endtask

  task automatic drive(input logic r, input logic w, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [BW-1:0] s);
    bus.tcdm_req_i   = r;
    bus.tcdm_we_i    = w;
    bus.tcdm_addr_i  = a;
    bus.tcdm_wdata_i = d;
    bus.tcdm_strb_i  = s;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, '0, '0, '0);
  endtask

  initial begin
    rst       = 1'b1;
    flip_req  = 1'b0;
    flip_addr = '0;
    idle();
    #2;
    chk1("rst_rvalid", bus.tcdm_rvalid_o, 1'b0);
    chk1("rst_ecc", bus.tcdm_ecc_err_o, 1'b0);
    chkc("rst_cnt", err_cnt, 2'd0);
    chk1("rst_gnt", bus.tcdm_gnt_o, 1'b0);
    chk1("rst_sreq", sram_req, 1'b0);
    tick();
    rst = 1'b0;

    // full write then read
    tick();
    drive(1'b1, 1'b1, 10'h12, 64'hDEADBEEF_01234567, 8'hFF);
    chk1("fw_gnt", bus.tcdm_gnt_o, 1'b1);
    chk1("fw_sreq", sram_req, 1'b1);
    chk1("fw_swe", sram_we, 1'b1);
    chkb("fw_be", sram_be, 8'hFF);
    chks("fw_wdata", sram_wdata, mk(64'hDEADBEEF_01234567));
    tick();
    drive(1'b1, 1'b0, 10'h12, '0, '0);
    chk1("fw_rvalid", bus.tcdm_rvalid_o, 1'b1);
    chk1("rd_gnt", bus.tcdm_gnt_o, 1'b1);
    chk1("rd_swe", sram_we, 1'b0);
    chkb("rd_be", sram_be, 8'hFF);
    tick();
    idle();
    chk1("rd_rvalid", bus.tcdm_rvalid_o, 1'b1);
    chkd("rd_data", bus.tcdm_rdata_o, 64'hDEADBEEF_01234567);
    chk1("rd_ecc", bus.tcdm_ecc_err_o, 1'b0);
    chk1("idle_gnt", bus.tcdm_gnt_o, 1'b0);
    chk1("idle_sreq", sram_req, 1'b0);

    // partial write
    tick();
    drive(1'b1, 1'b1, 10'h12, 64'hAA, 8'h01);
`ifdef DYN_MEM_BKGP_PARITY_EN
    chk1("pw0_gnt", bus.tcdm_gnt_o, 1'b0);
    chk1("pw0_sreq", sram_req, 1'b1);
    chk1("pw0_swe", sram_we, 1'b0);
    chka("pw0_addr", sram_addr, 10'h12);
    tick();
    chk1("pw1_gnt", bus.tcdm_gnt_o, 1'b1);
    chk1("pw1_swe", sram_we, 1'b1);
    chkb("pw1_be", sram_be, 8'hFF);
    chks("pw1_wdata", sram_wdata, mk(64'hDEADBEEF_012345AA));
    chk1("pw1_rvalid", bus.tcdm_rvalid_o, 1'b0);
`else
    chk1("pw0_gnt", bus.tcdm_gnt_o, 1'b1);
    chk1("pw0_swe", sram_we, 1'b1);
    chkb("pw0_be", sram_be, 8'h01);
    chka("pw0_addr", sram_addr, 10'h12);
    chks("pw0_wdata", sram_wdata, mk(64'hAA));
`endif
    tick();
    drive(1'b1, 1'b0, 10'h12, '0, '0);
    chk1("pw_rvalid", bus.tcdm_rvalid_o, 1'b1);
    chk1("pwr_gnt", bus.tcdm_gnt_o, 1'b1);
    tick();
    idle();
    chkd("pwr_data", bus.tcdm_rdata_o, 64'hDEADBEEF_012345AA);
    chk1("pwr_ecc", bus.tcdm_ecc_err_o, 1'b0);

    // strobe-less write: granted, no SRAM access, still answered
    tick();
    drive(1'b1, 1'b1, 10'h12, '1, 8'h00);
    chk1("nop_gnt", bus.tcdm_gnt_o, 1'b1);
    chk1("nop_sreq", sram_req, 1'b0);
    tick();
    idle();
    chk1("nop_rvalid", bus.tcdm_rvalid_o, 1'b1);
    tick();
    chk1("nop_rv_end", bus.tcdm_rvalid_o, 1'b0);

    // preload through the DUT with back-to-back full writes
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b1, AW'(i), sd(i), 8'hFF);
      tick();
    end
    drive(1'b1, 1'b1, 10'h30, 64'h00112233_44556677, 8'hFF);
    tick();
    drive(1'b1, 1'b1, 10'h40, 64'h0, 8'hFF);
    tick();
    drive(1'b1, 1'b1, 10'h20, 64'h01234567_89ABCDEF, 8'hFF);
    tick();
    idle();

    // 8 back-to-back reads
    for (int i = 0; i < 9; i++) begin
      tick();
      if (i < 8) drive(1'b1, 1'b0, AW'(i), '0, '0);
      else idle();
      if (i < 8) chk1("st_gnt", bus.tcdm_gnt_o, 1'b1);
      if (i > 0) begin
        chk1("st_rvalid", bus.tcdm_rvalid_o, 1'b1);
        chkd("st_data", bus.tcdm_rdata_o, sd(i - 1));
      end
    end
    tick();
    chk1("st_end", bus.tcdm_rvalid_o, 1'b0);

    // partial write in the middle of a read stream
    tick();
    drive(1'b1, 1'b0, 10'h0, '0, '0);
    chk1("ms0_gnt", bus.tcdm_gnt_o, 1'b1);
    tick();
    drive(1'b1, 1'b0, 10'h1, '0, '0);
    chk1("ms1_gnt", bus.tcdm_gnt_o, 1'b1);
    chkd("ms1_data", bus.tcdm_rdata_o, sd(0));
    tick();
    drive(1'b1, 1'b1, 10'h30, 64'hFFFFFFFF_AABBCCDD, 8'h0F);
    chk1("ms2_rvalid", bus.tcdm_rvalid_o, 1'b1);
    chkd("ms2_data", bus.tcdm_rdata_o, sd(1));
`ifdef DYN_MEM_BKGP_PARITY_EN
    chk1("ms2_gnt", bus.tcdm_gnt_o, 1'b0);
    tick();
    chk1("ms3_gnt", bus.tcdm_gnt_o, 1'b1);
    chk1("ms3_bubble", bus.tcdm_rvalid_o, 1'b0);
`else
    chk1("ms2_gnt", bus.tcdm_gnt_o, 1'b1);
`endif
    tick();
    drive(1'b1, 1'b0, 10'h2, '0, '0);
    chk1("ms4_gnt", bus.tcdm_gnt_o, 1'b1);
    chk1("ms4_rvalid", bus.tcdm_rvalid_o, 1'b1);
    tick();
    drive(1'b1, 1'b0, 10'h3, '0, '0);
    chk1("ms5_rvalid", bus.tcdm_rvalid_o, 1'b1);
    chkd("ms5_data", bus.tcdm_rdata_o, sd(2));
    tick();
    drive(1'b1, 1'b0, 10'h30, '0, '0);
    chkd("ms6_data", bus.tcdm_rdata_o, sd(3));
    tick();
    idle();
    chk1("ms7_rvalid", bus.tcdm_rvalid_o, 1'b1);
    chkd("ms7_data", bus.tcdm_rdata_o, 64'h00112233_AABBCCDD);
    tick();
    chk1("ms_end", bus.tcdm_rvalid_o, 1'b0);

`ifdef DYN_MEM_BKGP_PARITY_EN
    // corrupt word read: error flagged and counted
    flip_addr = 10'h20;
    flip_req  = 1'b1;
    tick();
    flip_req = 1'b0;
    drive(1'b1, 1'b0, 10'h20, '0, '0);
    chkc("pe_cnt0", err_cnt, 2'd0);
    tick();
    idle();
    chk1("pe_rvalid", bus.tcdm_rvalid_o, 1'b1);
    chk1("pe_ecc", bus.tcdm_ecc_err_o, 1'b1);
    chkd("pe_data", bus.tcdm_rdata_o, 64'h01234567_89ABCDE7);
    tick();
    chkc("pe_cnt1", err_cnt, 2'd1);
    chk1("pe_ecc_off", bus.tcdm_ecc_err_o, 1'b0);
    // RMW over the corrupt word counts but does not flag
    drive(1'b1, 1'b1, 10'h20, 64'h55, 8'h01);
    chk1("pe_pw0_gnt", bus.tcdm_gnt_o, 1'b0);
    tick();
    chk1("pe_pw1_gnt", bus.tcdm_gnt_o, 1'b1);
    chk1("pe_pw1_ecc", bus.tcdm_ecc_err_o, 1'b0);
    chks("pe_pw1_wd", sram_wdata, mk(64'h01234567_89ABCD55));
    tick();
    drive(1'b1, 1'b0, 10'h20, '0, '0);
    chkc("pe_cnt2", err_cnt, 2'd2);
    tick();
    idle();
    chkd("pe_fix_data", bus.tcdm_rdata_o, 64'h01234567_89ABCD55);
    chk1("pe_fix_ecc", bus.tcdm_ecc_err_o, 1'b0);
    tick();
    chkc("pe_cnt2b", err_cnt, 2'd2);

    // counter saturates
    flip_req = 1'b1;
    tick();
    flip_req = 1'b0;
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 1'b0, 10'h20, '0, '0);
      tick();
    end
    idle();
    chk1("sat_ecc", bus.tcdm_ecc_err_o, 1'b1);
    tick();
    chkc("sat_cnt", err_cnt, 2'd3);

    // reset during MERGE
    drive(1'b1, 1'b1, 10'h40, 64'h7700, 8'h02);
    chk1("rm0_gnt", bus.tcdm_gnt_o, 1'b0);
    tick();
    rst = 1'b1;
    #1;
    chk1("rm_swe", sram_we, 1'b0);
    chk1("rm_gnt", bus.tcdm_gnt_o, 1'b0);
    chk1("rm_rvalid", bus.tcdm_rvalid_o, 1'b0);
    chkc("rm_cnt", err_cnt, 2'd0);
    tick();
    chks("rm_nowrite", mem[10'h40], mk(64'h0));
    rst = 1'b0;
    #1;
    chk1("rm_re_gnt", bus.tcdm_gnt_o, 1'b0);
    chk1("rm_re_sreq", sram_req, 1'b1);
    chk1("rm_re_swe", sram_we, 1'b0);
    tick();
    chk1("rm_mg_gnt", bus.tcdm_gnt_o, 1'b1);
    chk1("rm_mg_swe", sram_we, 1'b1);
    chks("rm_mg_wd", sram_wdata, mk(64'h7700));
    tick();
    drive(1'b1, 1'b0, 10'h40, '0, '0);
    chk1("rm_rvalid2", bus.tcdm_rvalid_o, 1'b1);
    tick();
    idle();
    chkd("rm_data", bus.tcdm_rdata_o, 64'h7700);
`else
    chkc("np_cnt", err_cnt, 2'd0);
    chk1("np_ecc", bus.tcdm_ecc_err_o, 1'b0);
`endif

    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
